// File: rtl/branch_predictor_btb_pkg.sv
// Shared types and encodings for the direct-mapped branch target buffer.
// Tags are stored zero-extended to a fixed width so the entry struct is index-size independent.
package branch_predictor_btb_pkg;

    typedef enum logic [1:0] {
        FLAG_NONE = 2'b00,
        FLAG_NT   = 2'b01,
        FLAG_T    = 2'b10,
        FLAG_JMP  = 2'b11
    } upd_flag_e;

    localparam logic [1:0] STRONG_NT = 2'b00;
    localparam logic [1:0] WEAK_NT   = 2'b01;
    localparam logic [1:0] WEAK_T    = 2'b10;
    localparam logic [1:0] STRONG_T  = 2'b11;

    localparam int TAG_MAX_W = 30;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [31:0]          target;
        logic [1:0]           counter;
    } btb_entry_t;

endpackage

// File: rtl/branch_predictor_btb_sat_counter2.sv
// Combinational 2-bit saturating increment/decrement used when training an entry.
module sat_counter2
    import branch_predictor_btb_pkg::*;
(
    input  logic [1:0] cnt_i,
    output logic [1:0] inc_o,
    output logic [1:0] dec_o
);

    always_comb begin
        inc_o = (cnt_i == STRONG_T)  ? STRONG_T  : cnt_i + 2'd1;
        dec_o = (cnt_i == STRONG_NT) ? STRONG_NT : cnt_i - 2'd1;
    end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB: combinational lookup on the fetch PC, training and a registered
// mispredict redirect driven by the resolution fields leaving the AD latch.
module branch_predictor_btb
    import branch_predictor_btb_pkg::*;
#(
    parameter int INDEX_BITS = 4,
    parameter int CNT_W      = 16
) (
    input  logic             stg_clk,
    input  logic             reset,
    input  logic             stg_ena,
    input  logic             stg_x,
    input  logic [31:0]      fetch_pc,
    output logic             pred_valid,
    output logic             pred_taken,
    output logic [1:0]       pred_counter,
    output logic [31:0]      pred_next_pc,
    input  logic [31:0]      upd_pc,
    input  logic [31:0]      upd_target,
    input  logic [1:0]       upd_flag,
    input  logic [1:0]       upd_counter,
    input  logic             upd_valid,
    input  logic             upd_prediction,
    output logic             mispredict,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int ENTRIES = 2 ** INDEX_BITS;

    // Register array rather than RAM so the asynchronous reset can clear every entry.
    btb_entry_t tbl_q [ENTRIES];

    logic [INDEX_BITS-1:0] fetch_idx, upd_idx;
    logic [TAG_MAX_W-1:0]  fetch_tag, upd_tag;
    btb_entry_t            fetch_e, upd_e;

    logic                  accept;
    logic                  upd_match;
    logic [1:0]            cnt_inc, cnt_dec;

    logic                  tbl_we;
    btb_entry_t            tbl_wdata;
    logic                  mis_cond;
    logic [31:0]           redirect_d;
    logic                  mispredict_d;
    logic [CNT_W-1:0]      count_d;

    logic                  mispredict_q;
    logic [31:0]           redirect_q;
    logic [CNT_W-1:0]      count_q;

    assign fetch_idx = fetch_pc[INDEX_BITS+1:2];
    assign fetch_tag = TAG_MAX_W'(fetch_pc[31:INDEX_BITS+2]);
    assign upd_idx   = upd_pc[INDEX_BITS+1:2];
    assign upd_tag   = TAG_MAX_W'(upd_pc[31:INDEX_BITS+2]);
    assign fetch_e   = tbl_q[fetch_idx];
    assign upd_e     = tbl_q[upd_idx];

    sat_counter2 u_sat (
        .cnt_i (upd_counter),
        .inc_o (cnt_inc),
        .dec_o (cnt_dec)
    );

    // Lookup reads the registered table, so a same-cycle write is not yet visible.
    always_comb begin
        pred_valid   = fetch_e.valid && (fetch_e.tag == fetch_tag);
        pred_counter = pred_valid ? fetch_e.counter : STRONG_NT;
        pred_taken   = pred_valid & pred_counter[1];
        pred_next_pc = pred_taken ? fetch_e.target : fetch_pc + 32'd4;
    end

    assign accept    = stg_ena && !stg_x;
    assign upd_match = upd_e.valid && (upd_e.tag == upd_tag);

    // Training starts from the lookup-time counter snapshot, not the stored counter.
    always_comb begin
        tbl_we     = 1'b0;
        tbl_wdata  = upd_e;
        mis_cond   = 1'b0;
        redirect_d = upd_pc + 32'd4;
        unique case (upd_flag_e'(upd_flag))
            FLAG_NONE: begin
                tbl_we          = upd_match;
                tbl_wdata.valid = 1'b0;
                mis_cond        = upd_prediction;
            end
            FLAG_NT: begin
                tbl_we            = upd_valid;
                tbl_wdata.counter = cnt_dec;
                mis_cond          = upd_prediction;
            end
            FLAG_T, FLAG_JMP: begin
                tbl_we            = 1'b1;
                tbl_wdata.valid   = 1'b1;
                tbl_wdata.tag     = upd_tag;
                tbl_wdata.target  = upd_target;
                if (upd_flag_e'(upd_flag) == FLAG_JMP) begin
                    tbl_wdata.counter = STRONG_T;
                end else begin
                    tbl_wdata.counter = upd_valid ? cnt_inc : WEAK_T;
                end
                mis_cond   = !upd_prediction || !upd_match || (upd_e.target != upd_target);
                redirect_d = upd_target;
            end
            default: ;
        endcase
    end

    assign mispredict_d = accept && mis_cond;
    assign count_d      = (&count_q) ? count_q : count_q + CNT_W'(1);

    always_ff @(posedge stg_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_q[i] <= '0;
            end
            mispredict_q <= 1'b0;
            redirect_q   <= '0;
            count_q      <= '0;
        end else begin
            mispredict_q <= mispredict_d;
            if (mispredict_d) begin
                redirect_q <= redirect_d;
                count_q    <= count_d;
            end
            if (accept && tbl_we) begin
                tbl_q[upd_idx] <= tbl_wdata;
            end
        end
    end

    assign mispredict       = mispredict_q;
    assign redirect_pc      = redirect_q;
    assign mispredict_count = count_q;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Randomized and directed checks of branch_predictor_btb against an array-based model.
module tb_branch_predictor_btb;

    localparam int IB = 4;
    localparam int CW = 4;
    localparam int NE = 16;

    logic          stg_clk = 1'b0;
    logic          reset = 1'b1;
    logic          stg_ena = 1'b0;
    logic          stg_x = 1'b0;
    logic [31:0]   fetch_pc = 32'h100;
    logic          pred_valid, pred_taken;
    logic [1:0]    pred_counter;
    logic [31:0]   pred_next_pc;
    logic [31:0]   upd_pc = '0;
    logic [31:0]   upd_target = '0;
    logic [1:0]    upd_flag = '0;
    logic [1:0]    upd_counter = '0;
    logic          upd_valid = 1'b0;
    logic          upd_prediction = 1'b0;
    logic          mispredict;
    logic [31:0]   redirect_pc;
    logic [CW-1:0] mispredict_count;

    branch_predictor_btb #(.INDEX_BITS(IB), .CNT_W(CW)) dut (
        .stg_clk          (stg_clk),
        .reset            (reset),
        .stg_ena          (stg_ena),
        .stg_x            (stg_x),
        .fetch_pc         (fetch_pc),
        .pred_valid       (pred_valid),
        .pred_taken       (pred_taken),
        .pred_counter     (pred_counter),
        .pred_next_pc     (pred_next_pc),
        .upd_pc           (upd_pc),
        .upd_target       (upd_target),
        .upd_flag         (upd_flag),
        .upd_counter      (upd_counter),
        .upd_valid        (upd_valid),
        .upd_prediction   (upd_prediction),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .mispredict_count (mispredict_count)
    );

    always #5 stg_clk = ~stg_clk;

    // Reference model: one slot per index, fields held as plain integers.
    bit          m_valid [NE];
    int unsigned m_tag   [NE];
    logic [31:0] m_tgt   [NE];
    int          m_cnt   [NE];
    bit          exp_mis;
    logic [31:0] exp_red;
    int          exp_cnt;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NE; i++) begin
            m_valid[i] = 0;
            m_tag[i]   = 0;
            m_tgt[i]   = '0;
            m_cnt[i]   = 0;
        end
        exp_mis = 0;
        exp_red = '0;
        exp_cnt = 0;
    endtask

    task automatic check_lookup();
        int          i;
        bit          hit;
        int          c;
        bit          tk;
        logic [31:0] nxt;
        i   = int'((fetch_pc / 4) % NE);
        hit = m_valid[i] && (m_tag[i] == fetch_pc / 64);
        c   = hit ? m_cnt[i] : 0;
        tk  = hit && (c >= 2);
        nxt = tk ? m_tgt[i] : fetch_pc + 32'd4;
        check_eq("pred_valid", pred_valid, hit);
        check_eq("pred_counter", pred_counter, c);
        check_eq("pred_taken", pred_taken, tk);
        check_eq("pred_next_pc", pred_next_pc, nxt);
    endtask

    task automatic model_update();
        int          i;
        bit          match;
        bit          mis;
        logic [31:0] red;
        exp_mis = 0;
        if (!stg_ena || stg_x) return;
        i     = int'((upd_pc / 4) % NE);
        match = m_valid[i] && (m_tag[i] == upd_pc / 64);
        red   = upd_pc + 32'd4;
        mis   = 0;
        case (upd_flag)
            2'd0: begin
                if (match) m_valid[i] = 0;
                mis = upd_prediction;
            end
            2'd1: begin
                if (upd_valid) m_cnt[i] = (upd_counter == 0) ? 0 : int'(upd_counter) - 1;
                mis = upd_prediction;
            end
            default: begin
                mis = !upd_prediction || !match || (m_tgt[i] != upd_target);
                red = upd_target;
                m_valid[i] = 1;
                m_tag[i]   = upd_pc / 64;
                m_tgt[i]   = upd_target;
                if (upd_flag == 2'd3) m_cnt[i] = 3;
                else m_cnt[i] = upd_valid ? ((upd_counter == 3) ? 3 : int'(upd_counter) + 1) : 2;
            end
        endcase
        if (mis) begin
            exp_mis = 1;
            exp_red = red;
            if (exp_cnt < (1 << CW) - 1) exp_cnt++;
        end
    endtask

    // One clock: lookup checked before the edge, registered outputs checked just after.
    task automatic cycle();
        @(negedge stg_clk);
        check_lookup();
        model_update();
        @(posedge stg_clk);
        #1;
        check_eq("mispredict", mispredict, exp_mis);
        check_eq("redirect_pc", redirect_pc, exp_red);
        check_eq("mispredict_count", mispredict_count, exp_cnt);
    endtask

    task automatic set_upd(input bit ena, input bit x, input logic [31:0] pc, input logic [31:0] tgt,
                           input logic [1:0] flag, input logic [1:0] cnt, input bit vld, input bit pred);
        stg_ena        = ena;
        stg_x          = x;
        upd_pc         = pc;
        upd_target     = tgt;
        upd_flag       = flag;
        upd_counter    = cnt;
        upd_valid      = vld;
        upd_prediction = pred;
    endtask

    task automatic idle();
        set_upd(0, 0, 32'h0, 32'h0, 2'd0, 2'd0, 0, 0);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        if ($urandom_range(0, 9) == 0) p = $urandom();
        else p = ($urandom_range(0, 3) << 6) | ($urandom_range(0, NE - 1) << 2);
        return p;
    endfunction

    initial begin
        model_reset();
        #12;
        reset = 1'b0;
        check_eq("rst_mispredict", mispredict, 0);
        check_eq("rst_redirect", redirect_pc, 0);
        check_eq("rst_count", mispredict_count, 0);

        // Cold miss
        fetch_pc = 32'h100;
        #1;
        check_eq("cold_valid", pred_valid, 0);
        check_eq("cold_counter", pred_counter, 0);
        check_eq("cold_next", pred_next_pc, 32'h104);
        cycle();

        // Cold taken branch allocates and redirects
        set_upd(1, 0, 32'h100, 32'h200, 2'd2, 2'd0, 0, 0);
        cycle();
        check_eq("cold_t_mis", mispredict, 1);
        check_eq("cold_t_red", redirect_pc, 32'h200);
        check_eq("cold_t_cnt", mispredict_count, 1);
        idle();
        #1;
        check_eq("alloc_valid", pred_valid, 1);
        check_eq("alloc_counter", pred_counter, 2'b10);
        check_eq("alloc_next", pred_next_pc, 32'h200);
        cycle();
        check_eq("mis_one_cycle", mispredict, 0);

        // Saturation at strongly taken
        repeat (3) begin
            set_upd(1, 0, 32'h100, 32'h200, 2'd2, 2'd3, 1, 1);
            cycle();
            check_eq("sat_t_mis", mispredict, 0);
        end
        idle();
        #1;
        check_eq("sat_t_counter", pred_counter, 2'b11);

        // Saturation at strongly not-taken
        set_upd(1, 0, 32'h100, 32'h200, 2'd1, 2'd0, 1, 1);
        cycle();
        check_eq("sat_nt_mis", mispredict, 1);
        check_eq("sat_nt_red", redirect_pc, 32'h104);
        set_upd(1, 0, 32'h100, 32'h200, 2'd1, 2'd0, 1, 0);
        cycle();
        check_eq("sat_nt_nomis", mispredict, 0);
        check_eq("sat_nt_hold", redirect_pc, 32'h104);
        idle();
        #1;
        check_eq("sat_nt_counter", pred_counter, 2'b00);
        check_eq("sat_nt_next", pred_next_pc, 32'h104);

        // Invalidate via non-branch resolution
        set_upd(1, 0, 32'h100, 32'h200, 2'd0, 2'd0, 1, 1);
        cycle();
        check_eq("inv_mis", mispredict, 1);
        check_eq("inv_red", redirect_pc, 32'h104);
        idle();
        #1;
        check_eq("inv_valid", pred_valid, 0);

        // Kill and enable gating
        set_upd(1, 0, 32'h100, 32'h200, 2'd2, 2'd0, 0, 0);
        cycle();
        set_upd(1, 1, 32'h100, 32'h200, 2'd0, 2'd0, 1, 1);
        cycle();
        check_eq("kill_mis", mispredict, 0);
        set_upd(0, 0, 32'h100, 32'h200, 2'd0, 2'd0, 1, 1);
        cycle();
        check_eq("ena_mis", mispredict, 0);
        idle();
        #1;
        check_eq("gated_valid", pred_valid, 1);

        // Same-cycle lookup and update at one index
        fetch_pc = 32'h100;
        set_upd(1, 0, 32'h100, 32'h300, 2'd3, 2'd2, 1, 1);
        #1;
        check_eq("same_cyc_old", pred_next_pc, 32'h200);
        cycle();
        idle();
        #1;
        check_eq("same_cyc_new", pred_next_pc, 32'h300);
        check_eq("same_cyc_cnt", pred_counter, 2'b11);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            fetch_pc = ($urandom_range(0, 1) == 0) ? rand_pc() : upd_pc;
            set_upd($urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0, rand_pc(),
                    ($urandom_range(0, 2) == 0) ? $urandom() : 32'h200 + ($urandom_range(0, 3) << 8),
                    2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            cycle();
        end

        // Asynchronous reset during a mispredict cycle
        set_upd(1, 0, 32'h540, 32'h500, 2'd3, 2'd0, 0, 0);
        cycle();
        check_eq("pre_rst_mis", mispredict, 1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("arst_mis", mispredict, 0);
        check_eq("arst_cnt", mispredict_count, 0);
        check_eq("arst_red", redirect_pc, 0);
        model_reset();
        idle();
        #1;
        reset = 1'b0;
        for (int k = 0; k < NE; k++) begin
            fetch_pc = 32'h540 + (k << 2);
            #1;
            check_eq("arst_empty", pred_valid, 0);
        end
        repeat (3) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_predictor_btb.md
# branch_predictor_btb

Direct-mapped branch target buffer with 2-bit saturating counters. It brackets the AD pipeline latch on both sides:
- **Lookup side:** a combinational lookup on the fetch PC produces the prediction fields (counter, valid, taken) that travel down the pipeline through the AD latch.
- **Update side:** it consumes the registered resolution fields leaving that latch (PC, resolved target, branch flag, prediction snapshot). From these it trains the table and issues a registered mispredict redirect to fetch.

## Interface

Parameters:
- INDEX_BITS, 4: table index width; ENTRIES = 2**INDEX_BITS.
- CNT_W, 16: width of the mispredict statistics counter.

Ports:
- stg_clk  in  1  stage clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- stg_ena  in  1  update enable; update inputs are consumed only when high.
- stg_x  in  1  stage kill; when high the update is discarded (priority over stg_ena).
- fetch_pc  in  32  PC being fetched this cycle.
- pred_valid  out  1  BTB hit for fetch_pc.
- pred_taken  out  1  pred_valid & pred_counter[1].
- pred_counter  out  2  stored counter on hit, 2'b00 on miss.
- pred_next_pc  out  32  stored target if pred_taken, else fetch_pc+4.
- upd_pc  in  32  PC of the instruction resolving this cycle.
- upd_target  in  32  resolved branch target.
- upd_flag  in  2  branch class:
  - 00 = not a branch
  - 01 = conditional, not taken
  - 10 = conditional, taken
  - 11 = unconditional jump
- upd_counter  in  2  counter snapshot taken at lookup.
- upd_valid  in  1  hit snapshot taken at lookup.
- upd_prediction  in  1  taken-prediction snapshot taken at lookup.
- mispredict  out  1  one-cycle redirect pulse.
- redirect_pc  out  32  fetch redirect address, valid while mispredict.
- mispredict_count  out  CNT_W  saturating mispredict total.

## Operation

**Addressing**
- Index = pc[INDEX_BITS+1:2].
- Tag = pc[31:INDEX_BITS+2].
- Each entry holds: valid, tag, target[31:0], counter[1:0].

**Lookup**
- Purely combinational.
- Hit = valid && tag match.

**Update**
- Performed only when stg_ena && !stg_x.
- Let E be the entry at upd_pc's index; E matches when valid and tag equal to upd_pc's tag.

| upd_flag | Table update | Mispredict condition | redirect_pc |
|---|---|---|---|
| 00 | If E matches: invalidate E | upd_prediction | upd_pc+4 |
| 01 | If upd_valid: counter = sat_dec(upd_counter). If !upd_valid: no allocation | upd_prediction | upd_pc+4 |
| 10 | Write valid, tag, target = upd_target, counter = upd_valid ? sat_inc(upd_counter) : 2'b10 | !upd_prediction, OR E does not match, OR E.target != upd_target (E sampled before write) | upd_target |
| 11 | As 10, but counter forced to 2'b11 | As 10 | upd_target |

- Counter arithmetic saturates at 00 and 11.
- Training is always based on the upd_counter snapshot, never the current table value; a concurrent retrain is overwritten by design.
- On a mispredict, mispredict_count increments and holds at all-ones.

## Timing

- Lookup outputs have zero latency.
- Table writes take effect at the rising edge where the update is accepted.
- Same-cycle lookup and update at the same index: lookup returns the pre-write contents; new contents are visible from the next cycle.
- mispredict/redirect_pc are registered:
  - asserted the cycle after the accepted update, for exactly one cycle;
  - mispredict returns to 0 at every edge without a new mispredict, including edges with stg_ena low or stg_x high;
  - redirect_pc holds its last value.
- Reset (asynchronous, any cycle):
  - all valid bits = 0, all counters = 00, targets and tags = 0;
  - mispredict = 0, redirect_pc = 0, mispredict_count = 0;
  - a pending redirect is dropped.
- After reset, lookups miss until the first taken update.

## Structure

- Shared package holds:
  - the upd_flag encodings (FLAG_NONE, FLAG_NT, FLAG_T, FLAG_JMP);
  - counter constants (STRONG_NT=00, WEAK_NT=01, WEAK_T=10, STRONG_T=11);
  - the BTB entry struct.
- One sub-module: sat_counter2, combinational inc/dec with saturation, used on the update path.
- Table is a register array; no RAM macro, because the asynchronous reset must clear valid bits.

## Test plan

- **Reset, then cold miss:** fetch_pc=0x100 → pred_valid=0, pred_counter=00, pred_next_pc=0x104.
- **Cold taken branch:** update upd_pc=0x100, flag=10, upd_valid=0, upd_prediction=0, target=0x200 → next cycle mispredict=1, redirect_pc=0x200, count=1. Then lookup 0x100 → hit, counter=10, pred_next_pc=0x200.
- **Saturation:** repeat taken updates with upd_counter=11 → counter stays 11, no mispredict. Not-taken updates with upd_counter=00 → counter stays 00, redirect_pc=0x104 only while upd_prediction=1.
- **Alias and invalidate:** entry for 0x100 present; update upd_pc=0x100, flag=00, upd_prediction=1 → entry invalidated, mispredict=1, redirect_pc=0x104.
- **Kill and enable gating:**
  - stg_x=1 with stg_ena=1 → no table change, mispredict=0;
  - stg_ena=0 → same result.
  - Same-cycle lookup and update at one index → lookup shows old entry.
- **Asynchronous reset:** assert reset in the cycle mispredict=1 → mispredict drops immediately, table empty, count=0.
